// File: rtl/alu_cmd_sequencer_if.sv
// Command / ALU / response bus of the ALU command sequencer.
// Opcodes are 3-bit: ADD=0 SUB=1 MUL=2 DIV=3 MOD=4; codes 5..7 are invalid.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;

    logic       alu_start;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_mode_select;
    logic [7:0] alu_c;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
        input  cmd_ready, alu_start, alu_a, alu_b, alu_mode_select,
               rsp_valid, rsp_result, rsp_op, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
        output cmd_ready, alu_start, alu_a, alu_b, alu_mode_select,
               rsp_valid, rsp_result, rsp_op, rsp_err, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a FIFO, issues them one at a time to an external
// registered ALU and returns each result (or a rejection) in acceptance order.
package tb_pkg;
    typedef logic [2:0] opcode_t;
    localparam opcode_t OP_ADD = 3'd0;
    localparam opcode_t OP_SUB = 3'd1;
    localparam opcode_t OP_MUL = 3'd2;
    localparam opcode_t OP_DIV = 3'd3;
    localparam opcode_t OP_MOD = 3'd4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        opcode_t    op;
    } cmd_t;
endpackage

module alu_cmd_sequencer
    import tb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
    input logic                 clock,
    input logic                 reset,
    alu_cmd_sequencer_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;

    cmd_t          cmd_in, head;
    logic          push, pop, head_bad, fifo_empty;

    logic          alu_start_q;
    logic [7:0]    alu_a_q, alu_b_q;
    opcode_t       alu_mode_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [7:0]    rsp_result_q;
    opcode_t       rsp_op_q;

    assign cmd_in     = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
    assign head       = mem[rd_ptr];
    assign fifo_empty = (count == '0);

    // Divide-by-zero and unknown opcodes never reach the ALU.
    assign head_bad = (head.op > OP_MOD) ||
                      (((head.op == OP_DIV) || (head.op == OP_MOD)) && (head.b == 8'd0));

    // cmd_ready is purely not-full; a same-cycle pop does not open a slot.
    assign bus.cmd_ready = (count != DEPTH_CNT);
    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop  = (state == S_ISSUE) ||
                  ((state == S_IDLE) && !fifo_empty && head_bad);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            alu_start_q  <= 1'b0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            alu_mode_q   <= OP_ADD;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 8'd0;
            rsp_op_q     <= OP_ADD;
            rsp_err_q    <= 1'b0;
        end else begin
            alu_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        if (head_bad) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_result_q <= 8'd0;
                            rsp_op_q     <= head.op;
                            rsp_err_q    <= 1'b1;
                            state        <= S_RESPOND;
                        end else begin
                            // Strobe is registered so it lines up with the ISSUE cycle.
                            alu_a_q     <= head.a;
                            alu_b_q     <= head.b;
                            alu_mode_q  <= head.op;
                            alu_start_q <= 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state <= S_CAPTURE;
                S_CAPTURE: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= bus.alu_c;
                    rsp_op_q     <= alu_mode_q;
                    rsp_err_q    <= 1'b0;
                    state        <= S_RESPOND;
                end
                S_RESPOND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_start       = alu_start_q;
    assign bus.alu_a           = alu_a_q;
    assign bus.alu_b           = alu_b_q;
    assign bus.alu_mode_select = alu_mode_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_result      = rsp_result_q;
    assign bus.rsp_op          = rsp_op_q;
    assign bus.rsp_err         = rsp_err_q;
    assign bus.busy            = (state != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: table vectors, directed multi-cycle sequences
// and random traffic scored against an in-order queue model with a registered ALU.
module tb_alu_cmd_sequencer;
    import tb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int rsp_count = 0;
    int acc_count = 0;

    typedef struct {
        logic [7:0] res;
        logic [2:0] op;
        logic       err;
    } rsp_rec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_rec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       err;
    } vec_t;

    rsp_rec_t exp_q[$];
    cmd_rec_t iss_q[$];
    rsp_rec_t er, held;
    cmd_rec_t ic;
    logic     hold_vld = 1'b0;
    logic     prev_start = 1'b0;
    logic     rej;

    vec_t vt[14];
    cmd_rec_t seqc[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic on the operands, truncated to 8 bits.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        int ia, ib, r;
        ia = a;
        ib = b;
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib;
            3'd2:    r = ia * ib;
            3'd3:    r = (ib == 0) ? 0 : ia / ib;
            3'd4:    r = (ib == 0) ? 0 : ia % ib;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic logic is_rej(input logic [7:0] b, input logic [2:0] op);
        return (op > 3'd4) || ((op == 3'd3 || op == 3'd4) && b == 8'd0);
    endfunction

    // External registered ALU.
    always @(posedge clock) begin
        if (reset) bus.alu_c <= 8'd0;
        else if (bus.alu_start) bus.alu_c <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_mode_select);
    end

    // Scoreboard: every accepted command yields one response, in order.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            iss_q.delete();
            hold_vld   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (bus.alu_start) begin
                chk("start_pulse_width", int'(prev_start), 0);
                chk("start_pending", int'(iss_q.size() != 0), 1);
                if (iss_q.size() != 0) begin
                    ic = iss_q.pop_front();
                    chk("issue_a", bus.alu_a, ic.a);
                    chk("issue_b", bus.alu_b, ic.b);
                    chk("issue_mode", bus.alu_mode_select, ic.op);
                end
            end
            prev_start = bus.alu_start;
            if (hold_vld) begin
                chk("rsp_hold_valid", bus.rsp_valid, 1);
                chk("rsp_hold_result", bus.rsp_result, held.res);
                chk("rsp_hold_op", bus.rsp_op, held.op);
                chk("rsp_hold_err", bus.rsp_err, held.err);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_pending", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    er = exp_q.pop_front();
                    chk("rsp_result", bus.rsp_result, er.res);
                    chk("rsp_op", bus.rsp_op, er.op);
                    chk("rsp_err", bus.rsp_err, er.err);
                end
                rsp_count++;
            end
            hold_vld = bus.rsp_valid && !bus.rsp_ready;
            held = '{res: bus.rsp_result, op: bus.rsp_op, err: bus.rsp_err};
            if (bus.cmd_valid && bus.cmd_ready) begin
                rej = is_rej(bus.cmd_b, bus.cmd_op);
                er = '{res: rej ? 8'd0 : alu_fn(bus.cmd_a, bus.cmd_b, bus.cmd_op),
                       op: bus.cmd_op, err: rej};
                exp_q.push_back(er);
                if (!rej) iss_q.push_back('{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op});
                acc_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bus.cmd_valid = 1'b1;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_op = op;
    endtask

    // Isolated command into an idle block; measures issue and response cycles.
    task automatic run_vec(input int idx, input vec_t v);
        int start_c, rsp_c;
        logic [7:0] res;
        logic [2:0] op;
        logic err;
        start_c = -1; rsp_c = -1; res = 8'd0; op = 3'd0; err = 1'b0;
        chk($sformatf("vec%0d_idle", idx), int'(bus.busy), 0);
        drive(v.a, v.b, v.op);
        bus.rsp_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) bus.cmd_valid = 1'b0;
            if (bus.alu_start && start_c < 0) start_c = c;
            if (bus.rsp_valid && rsp_c < 0) begin
                rsp_c = c;
                res = bus.rsp_result;
                op = bus.rsp_op;
                err = bus.rsp_err;
            end
        end
        chk($sformatf("vec%0d_start_cycle", idx), start_c, v.err ? -1 : 2);
        chk($sformatf("vec%0d_rsp_cycle", idx), rsp_c, v.err ? 2 : 4);
        chk($sformatf("vec%0d_result", idx), res, v.res);
        chk($sformatf("vec%0d_op", idx), op, v.op);
        chk($sformatf("vec%0d_err", idx), err, v.err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, accepted, low_c, idx, found, base_a, base_r;

        vt[0]  = '{8'd200, 8'd100, 3'd0, 8'd44,  1'b0};
        vt[1]  = '{8'd5,   8'd9,   3'd1, 8'd252, 1'b0};
        vt[2]  = '{8'd16,  8'd17,  3'd2, 8'd16,  1'b0};
        vt[3]  = '{8'd7,   8'd0,   3'd3, 8'd0,   1'b1};
        vt[4]  = '{8'd9,   8'd0,   3'd4, 8'd0,   1'b1};
        vt[5]  = '{8'd200, 8'd7,   3'd3, 8'd28,  1'b0};
        vt[6]  = '{8'd200, 8'd7,   3'd4, 8'd4,   1'b0};
        vt[7]  = '{8'd1,   8'd2,   3'd5, 8'd0,   1'b1};
        vt[8]  = '{8'd3,   8'd4,   3'd7, 8'd0,   1'b1};
        vt[9]  = '{8'd255, 8'd1,   3'd0, 8'd0,   1'b0};
        vt[10] = '{8'd255, 8'd255, 3'd2, 8'd1,   1'b0};
        vt[11] = '{8'd0,   8'd5,   3'd3, 8'd0,   1'b0};
        vt[12] = '{8'd0,   8'd0,   3'd1, 8'd0,   1'b0};
        vt[13] = '{8'd255, 8'd16,  3'd4, 8'd15,  1'b0};

        seqc[0] = '{8'd16,  8'd17, 3'd2};
        seqc[1] = '{8'd5,   8'd9,  3'd1};
        seqc[2] = '{8'd1,   8'd2,  3'd0};
        seqc[3] = '{8'd100, 8'd3,  3'd3};
        seqc[4] = '{8'd100, 8'd3,  3'd4};
        seqc[5] = '{8'd9,   8'd9,  3'd0};

        bus.cmd_valid = 1'b0;
        bus.cmd_a = 8'd0;
        bus.cmd_b = 8'd0;
        bus.cmd_op = 3'd0;
        bus.rsp_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_alu_start", bus.alu_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mode", bus.alu_mode_select, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_op", bus.rsp_op, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);

        // Table vectors
        foreach (vt[i]) run_vec(i, vt[i]);
        chk("alu_regs_hold_a", bus.alu_a, 255);
        chk("alu_regs_hold_mode", bus.alu_mode_select, 4);

        // Fill the FIFO with the response side stalled
        do_reset();
        bus.rsp_ready = 1'b0;
        accepted = 0; low_c = -1; idx = 0;
        for (int c = 0; c < 8; c++) begin
            drive(seqc[(idx < 6) ? idx : 5].a, seqc[(idx < 6) ? idx : 5].b,
                  seqc[(idx < 6) ? idx : 5].op);
            if (bus.cmd_ready) begin
                accepted++;
                idx++;
            end else if (low_c < 0) begin
                low_c = c;
            end
            tick();
        end
        chk("fill_ready_low_cycle", low_c, 5);
        chk("fill_accepted", accepted, 5);
        chk("fill_ready_still_low", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        base = rsp_count;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 60 && rsp_count - base < 5; k++) tick();
        chk("fill_responses", rsp_count - base, 5);
        tick();
        chk("fill_drained_busy", bus.busy, 0);

        // Response held across backpressure
        bus.rsp_ready = 1'b0;
        drive(8'd5, 8'd9, 3'd1);
        tick();
        bus.cmd_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.rsp_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("hold_rsp_seen", found, 1);
        base = rsp_count;
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_result", bus.rsp_result, 252);
            tick();
        end
        chk("hold_valid_last", bus.rsp_valid, 1);
        chk("hold_no_early_hs", rsp_count - base, 0);
        bus.rsp_ready = 1'b1;
        tick();
        chk("hold_single_hs", rsp_count - base, 1);
        chk("hold_valid_drop", bus.rsp_valid, 0);

        // Reset during CAPTURE with two queued, plus a push on the reset edge
        do_reset();
        bus.rsp_ready = 1'b1;
        drive(8'd10, 8'd20, 3'd0);
        tick();
        drive(8'd30, 8'd40, 3'd1);
        tick();
        chk("midrst_issue", bus.alu_start, 1);
        drive(8'd50, 8'd5, 3'd3);
        tick();
        chk("midrst_capture_busy", bus.busy, 1);
        chk("midrst_capture_no_rsp", bus.rsp_valid, 0);
        drive(8'd60, 8'd6, 3'd2);
        reset = 1'b1;
        base = rsp_count;
        tick();
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        for (int k = 0; k < 20; k++) tick();
        chk("midrst_no_response", rsp_count - base, 0);
        chk("midrst_still_idle", bus.busy, 0);

        // Random traffic
        base_a = acc_count;
        base_r = rsp_count;
        for (int i = 0; i < 1500; i++) begin
            bus.cmd_valid = ($urandom_range(0, 1) == 1);
            bus.cmd_a = 8'($urandom);
            bus.cmd_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            bus.cmd_op = 3'($urandom_range(0, 7));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.busy); k++) tick();
        chk("rand_drain_queue", exp_q.size(), 0);
        chk("rand_drain_busy", bus.busy, 0);
        chk("rand_rsp_per_cmd", rsp_count - base_r, acc_count - base_a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
